// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port memory between instruction fetch (IF, read only)
//   and data (D, load/store) requesters. One access at a time: the winner is
//   latched in an accept slot, driven onto the memory port during ACCESS and
//   answered with a one-cycle response in RESP. RESP is itself an accept
//   slot, so back-to-back traffic reaches one access every two cycles.
//   D wins by default. IF wins once it has been waiting MAX_WAIT cycles.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   if_req_i/if_addr_i              fetch request
//   if_gnt_o                        fetch accepted this cycle (combinational)
//   if_rsp_vld_o/if_rdata_o         fetch response pulse / held read data
//   d_req_i/d_we_i/d_addr_i/d_wdata_i  data request (d_we_i=1 store)
//   d_gnt_o                         data accepted this cycle (combinational)
//   d_rsp_vld_o/d_rdata_o           data response pulse / load data (0 on store)
//   mem_addr_o/mem_data_o           memory address / write data
//   mem_read_en_o/mem_write_en_o    memory strobes, valid in ACCESS only
//   mem_data_i/mem_data_vld_i       memory read data / read data valid
//   busy_o                          an access or response is in progress
//
// Optional build macro ARB_STATS_EN adds two free-running counters:
//   stat_conflict_o  accept-slot cycles with both requests present
//   stat_if_stall_o  cycles with a fetch request that was not granted
module mem_arbiter #(
  parameter int unsigned       AWIDTH     = 32,
  parameter int unsigned       DWIDTH     = 32,
  parameter logic [AWIDTH-1:0] RESET_ADDR = 32'h0100_0000,
  parameter int unsigned       MAX_WAIT   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rsp_vld_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rsp_vld_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i,
  input  logic              mem_data_vld_i,
  output logic              busy_o
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       stat_conflict_o,
  output logic [31:0]       stat_if_stall_o
`endif
);

  localparam int unsigned     WW       = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0]   WAIT_SAT = WW'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_cnt;
  logic          owner_if_q;  // 1: current access belongs to IF
  logic          we_q;
  logic          accept;
  logic          if_win;
  logic          capture;

  always_comb begin
    state_d        = state_q;
    accept         = (state_q != ACCESS);
    // D wins unless it is absent or IF has waited long enough.
    if_win         = if_req_i && (!d_req_i || (wait_cnt >= WAIT_SAT));
    if_gnt_o       = accept && if_win;
    d_gnt_o        = accept && d_req_i && !if_win;
    mem_read_en_o  = (state_q == ACCESS) && !we_q;
    mem_write_en_o = (state_q == ACCESS) && we_q;
    if_rsp_vld_o   = (state_q == RESP) && owner_if_q;
    d_rsp_vld_o    = (state_q == RESP) && !owner_if_q;
    busy_o         = (state_q != IDLE);
    // Stores finish after their single write cycle; reads wait for valid.
    capture        = (state_q == ACCESS) && (we_q || mem_data_vld_i);

    case (state_q)
      IDLE, RESP: state_d = (if_gnt_o || d_gnt_o) ? ACCESS : IDLE;
      ACCESS:     state_d = capture ? RESP : ACCESS;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt   <= '0;
      owner_if_q <= 1'b0;
      we_q       <= 1'b0;
      mem_addr_o <= RESET_ADDR;
      mem_data_o <= '0;
      if_rdata_o <= '0;
      d_rdata_o  <= '0;
    end else begin
      state_q <= state_d;

      if (if_gnt_o) begin
        owner_if_q <= 1'b1;
        we_q       <= 1'b0;
        mem_addr_o <= if_addr_i;
        mem_data_o <= '0;
      end else if (d_gnt_o) begin
        owner_if_q <= 1'b0;
        we_q       <= d_we_i;
        mem_addr_o <= d_addr_i;
        mem_data_o <= d_wdata_i;
      end

      if (capture) begin
        if (we_q) begin
          d_rdata_o <= '0;
        end else if (owner_if_q) begin
          if_rdata_o <= mem_data_i;
        end else begin
          d_rdata_o <= mem_data_i;
        end
      end

      if (if_gnt_o) begin
        wait_cnt <= '0;
      end else if (if_req_i && (wait_cnt != WAIT_SAT)) begin
        wait_cnt <= wait_cnt + WW'(1);
      end
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_conflict_o <= '0;
      stat_if_stall_o <= '0;
    end else begin
      if (accept && if_req_i && d_req_i) begin
        stat_conflict_o <= stat_conflict_o + 32'd1;
      end
      if (if_req_i && !if_gnt_o) begin
        stat_if_stall_o <= stat_if_stall_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios with literal expectations,
// plus a transaction-level model compared against the DUT every cycle.
module tb_mem_arbiter;

  localparam logic [31:0] RST_ADDR = 32'h0100_0000;
  localparam int          MAXW     = 4;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rsp_vld;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rsp_vld;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_rdata;
  logic        mem_data_vld;
  logic        busy;
`ifdef ARB_STATS_EN
  logic [31:0] stat_conflict;
  logic [31:0] stat_if_stall;
`endif

  mem_arbiter #(
    .AWIDTH    (32),
    .DWIDTH    (32),
    .RESET_ADDR(RST_ADDR),
    .MAX_WAIT  (MAXW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_i      (if_req),
    .if_addr_i     (if_addr),
    .if_gnt_o      (if_gnt),
    .if_rsp_vld_o  (if_rsp_vld),
    .if_rdata_o    (if_rdata),
    .d_req_i       (d_req),
    .d_we_i        (d_we),
    .d_addr_i      (d_addr),
    .d_wdata_i     (d_wdata),
    .d_gnt_o       (d_gnt),
    .d_rsp_vld_o   (d_rsp_vld),
    .d_rdata_o     (d_rdata),
    .mem_addr_o    (mem_addr),
    .mem_data_o    (mem_wdata),
    .mem_read_en_o (mem_read_en),
    .mem_write_en_o(mem_write_en),
    .mem_data_i    (mem_rdata),
    .mem_data_vld_i(mem_data_vld),
    .busy_o        (busy)
`ifdef ARB_STATS_EN
    ,
    .stat_conflict_o(stat_conflict),
    .stat_if_stall_o(stat_if_stall)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: 256 words, word index from address bits [9:2]. Reads are
  // combinational; valid asserts after vld_delay cycles of read enable.
  logic [31:0] mem [256];
  int          vld_delay = 0;
  int          rd_cycles = 0;

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'h0000_0013 : (32'hC0DE_0000 + 32'(i));
  endfunction

  assign mem_rdata    = mem[mem_addr[9:2]];
  assign mem_data_vld = mem_read_en && (rd_cycles >= vld_delay);

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_write_en) mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  always @(posedge clk) rd_cycles <= mem_read_en ? rd_cycles + 1 : 0;

  // Transaction model: at most one access outstanding; a response follows
  // its completion by one cycle; accept slots are cycles with nothing in
  // the memory phase.
  logic [31:0] model_mem [256];
  bit          m_inflight, m_resp, m_owner_if, m_we;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
  int          m_wait;
  int          m_conf, m_stall;
  bit          e_accept, e_if_gnt, e_d_gnt;

  task automatic model_reset();
    m_inflight = 0; m_resp = 0; m_owner_if = 0; m_we = 0;
    m_addr = RST_ADDR; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0;
    m_wait = 0; m_conf = 0; m_stall = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
      end else begin
        e_accept = !m_inflight;
        e_if_gnt = e_accept && if_req && (!d_req || m_wait >= MAXW);
        e_d_gnt  = e_accept && d_req && !e_if_gnt;
        check("m_if_gnt", if_gnt, e_if_gnt);
        check("m_d_gnt", d_gnt, e_d_gnt);
        check("m_rd_en", mem_read_en, m_inflight && !m_we);
        check("m_wr_en", mem_write_en, m_inflight && m_we);
        check("m_addr", mem_addr, m_addr);
        if (m_inflight && m_we) check("m_wdata", mem_wdata, m_wdata);
        check("m_if_rsp", if_rsp_vld, m_resp && m_owner_if);
        check("m_d_rsp", d_rsp_vld, m_resp && !m_owner_if);
        check("m_if_rdata", if_rdata, m_if_rdata);
        check("m_d_rdata", d_rdata, m_d_rdata);
        check("m_busy", busy, m_inflight || m_resp);
`ifdef ARB_STATS_EN
        check("m_stat_conf", stat_conflict, 32'(m_conf));
        check("m_stat_stall", stat_if_stall, 32'(m_stall));
`endif
        if (e_accept && if_req && d_req) m_conf++;
        if (if_req && !e_if_gnt) m_stall++;
        if (e_if_gnt) m_wait = 0;
        else if (if_req && m_wait < MAXW) m_wait++;

        if (m_inflight) begin
          if (m_we || mem_data_vld) begin
            m_inflight = 0;
            m_resp     = 1;
            if (m_we) begin
              model_mem[m_addr[9:2]] = m_wdata;
              m_d_rdata = '0;
            end else if (m_owner_if) begin
              m_if_rdata = model_mem[m_addr[9:2]];
            end else begin
              m_d_rdata = model_mem[m_addr[9:2]];
            end
          end
        end else begin
          m_resp = 0;
          if (e_if_gnt) begin
            m_inflight = 1; m_owner_if = 1; m_we = 0; m_addr = if_addr; m_wdata = '0;
          end else if (e_d_gnt) begin
            m_inflight = 1; m_owner_if = 0; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  byte seq[$];
  byte exp_seq [6];

  initial begin
    exp_seq = '{"D", "D", "I", "D", "D", "I"};
    rst_n = 1'b0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", mem_addr, RST_ADDR);
    check("rst_busy", busy, 0);
    check("rst_wr_en", mem_write_en, 0);
    check("rst_rd_en", mem_read_en, 0);
    check("rst_if_rdata", if_rdata, 0);
    rst_n = 1'b1;

    // IF-only fetch from memory base.
    next_cycle();
    if_req = 1; if_addr = 32'h0100_0000;
    @(negedge clk); check("if_gnt_c0", if_gnt, 1); check("d_gnt_c0", d_gnt, 0);
    next_cycle(); if_req = 0;
    @(negedge clk); check("if_rd_en_c1", mem_read_en, 1); check("if_addr_c1", mem_addr, 32'h0100_0000);
    next_cycle();
    @(negedge clk); check("if_rsp_c2", if_rsp_vld, 1); check("if_rdata_c2", if_rdata, 32'h13);
    next_cycle();

    // Store then load the same address.
    d_req = 1; d_we = 1; d_addr = 32'h0100_0010; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk); check("st_gnt", d_gnt, 1);
    next_cycle(); d_req = 0; d_we = 0; d_wdata = '0;
    @(negedge clk); check("st_wr_en", mem_write_en, 1); check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    next_cycle();
    @(negedge clk); check("st_rsp", d_rsp_vld, 1); check("st_rdata", d_rdata, 0); check("st_wr_off", mem_write_en, 0);
    next_cycle();
    d_req = 1; d_addr = 32'h0100_0010;
    @(negedge clk); check("ld_gnt", d_gnt, 1);
    next_cycle(); d_req = 0;
    @(negedge clk); check("ld_rd_en", mem_read_en, 1);
    next_cycle();
    @(negedge clk); check("ld_rsp", d_rsp_vld, 1); check("ld_rdata", d_rdata, 32'hDEAD_BEEF);
    check("if_rdata_hold", if_rdata, 32'h13);
    next_cycle();

    // Both requesters held: grant order follows the starvation bound.
    if_req = 1; if_addr = 32'h0100_0004; d_req = 1; d_we = 0; d_addr = 32'h0100_0008;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("both_gnt", if_gnt && d_gnt, 0);
      if (if_gnt) seq.push_back("I");
      if (d_gnt) seq.push_back("D");
      next_cycle();
    end
    if_req = 0; d_req = 0;
    check("arb_slots", seq.size(), 6);
    for (int k = 0; k < 6 && k < seq.size(); k++) check("arb_seq", seq[k], exp_seq[k]);
    next_cycle();

    // Load with delayed read valid.
    vld_delay = 3;
    d_req = 1; d_addr = 32'h0100_0008;
    @(negedge clk); check("dly_gnt", d_gnt, 1);
    next_cycle(); d_req = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("dly_vld_low", mem_data_vld, 0); check("dly_rsp_low", d_rsp_vld, 0); check("dly_rd_en", mem_read_en, 1);
      next_cycle();
    end
    @(negedge clk); check("dly_vld_high", mem_data_vld, 1); check("dly_rsp_early", d_rsp_vld, 0);
    next_cycle();
    @(negedge clk); check("dly_rsp", d_rsp_vld, 1); check("dly_rdata", d_rdata, 32'hC0DE_0002);
    next_cycle();
    @(negedge clk); check("dly_rsp_once", d_rsp_vld, 0);
    next_cycle();
    vld_delay = 0;

    // Reset during the write cycle of a store.
    d_req = 1; d_we = 1; d_addr = 32'h0100_0020; d_wdata = 32'h1234_5678;
    @(negedge clk); check("rs_gnt", d_gnt, 1);
    next_cycle(); d_req = 0; d_we = 0; d_wdata = '0;
    #2; check("rs_wr_before", mem_write_en, 1);
    rst_n = 1'b0;
    #1;
    check("rs_wr_drop", mem_write_en, 0); check("rs_busy", busy, 0); check("rs_addr", mem_addr, RST_ADDR);
    next_cycle();
    check("rs_mem_kept", mem[8], 32'hC0DE_0008);
    rst_n = 1'b1;
    @(negedge clk); check("rs_no_rsp", d_rsp_vld, 0); check("rs_idle", busy, 0);
    next_cycle();

    // Ten cycles of both requests from a fresh reset.
    if_req = 1; if_addr = 32'h0100_0000; d_req = 1; d_we = 0; d_addr = 32'h0100_0004;
    repeat (10) next_cycle();
    if_req = 0; d_req = 0;
`ifdef ARB_STATS_EN
    @(negedge clk); check("stat_conflict", stat_conflict, 5); check("stat_stall", stat_if_stall, 9);
`endif
    repeat (4) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: simulation still running at t=%0t, limit 100000", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
